line_shift_engine: RTL and testbench

LINE_SHIFT_ENGINE -- requirements
Module: line_shift_engine

---
 rtl/game_pkg.sv | 13 +
 rtl/line_reverse.sv | 12 +
 rtl/line_shift_engine.sv | 179 +++++++++++++++++
 tb/tb_line_shift_engine.sv | 163 ++++++++++++++++
 4 files changed

// File: rtl/game_pkg.sv
// game_pkg: shared FSM state, default line geometry, tile type and score width helper
package game_pkg;
    localparam int DEF_LEN = 4;
    localparam int DEF_VW  = 4;

    typedef enum logic [2:0] {S_IDLE, S_LOAD, S_SCAN, S_FLUSH, S_DONE} state_t;

    typedef logic [DEF_VW-1:0] tile_t;

    function automatic int score_w(input int vw);
        return (1 << vw) + 1;
    endfunction
endpackage

// File: rtl/line_reverse.sv
// line_reverse: combinational tile-order reversal of a LEN-tile line
module line_reverse #(
    parameter int LEN = 4,
    parameter int VW  = 4
) (
    input  logic [LEN*VW-1:0] line_i,
    output logic [LEN*VW-1:0] line_o
);
    for (genvar g = 0; g < LEN; g++) begin : g_rev
        assign line_o[g*VW +: VW] = line_i[(LEN-1-g)*VW +: VW];
    end
endmodule

// File: rtl/line_shift_engine.sv
// line_shift_engine: sequential pack/merge of one tile line; score accumulator present only with LINE_SHIFT_SCORE_EN
module line_shift_engine
    import game_pkg::*;
#(
    parameter int LEN = DEF_LEN,
    parameter int VW  = DEF_VW
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         start,
    input  logic                         dir,
    input  logic [LEN*VW-1:0]            line_in,
    output logic [LEN*VW-1:0]            line_out,
    output logic                         busy,
    output logic                         done,
    output logic                         moved,
    output logic [$clog2(LEN/2+1)-1:0]   merge_cnt,
    output logic [score_w(VW)-1:0]       score_add
);
    localparam int LW = LEN * VW;
    localparam int MW = $clog2(LEN/2+1);
    localparam int SW = score_w(VW);
    localparam int PW = $clog2(LEN+1);
    localparam int CW = $clog2(LEN);
    localparam logic [VW-1:0] MAXV = {VW{1'b1}};

    state_t        state_q, state_d;
    logic [LW-1:0] in_q, in_d, work_q, work_d, res_q, res_d, out_q, out_d;
    logic [LW-1:0] rin, rout;
    logic          dir_q, dir_d, moved_q, moved_d, done_q, done_d;
    logic [VW-1:0] pend_q, pend_d, tile, wr_val;
    logic [PW-1:0] wp_q, wp_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [MW-1:0] mcnt_q, mcnt_d, mout_q, mout_d;
    logic          wr_en, mrg;

    line_reverse #(.LEN(LEN), .VW(VW)) u_rev_in  (.line_i(in_q),  .line_o(rin));
    line_reverse #(.LEN(LEN), .VW(VW)) u_rev_out (.line_i(res_q), .line_o(rout));

    // working line is shifted down one tile per SCAN cycle, so the current tile is always the low slice
    assign tile = work_q[VW-1:0];
    assign mrg  = (state_q == S_SCAN) && (tile != '0) && (tile == pend_q) && (pend_q != MAXV);

    // next-state and datapath: capture, load, streaming merge, flush, publish
    always_comb begin
        state_d = state_q;
        in_d    = in_q;
        dir_d   = dir_q;
        work_d  = work_q;
        res_d   = res_q;
        pend_d  = pend_q;
        wp_d    = wp_q;
        cnt_d   = cnt_q;
        mcnt_d  = mcnt_q;
        out_d   = out_q;
        moved_d = moved_q;
        mout_d  = mout_q;
        done_d  = 1'b0;
        wr_en   = 1'b0;
        wr_val  = '0;
        case (state_q)
            S_IDLE: if (start && !done_q) begin
                in_d    = line_in;
                dir_d   = dir;
                state_d = S_LOAD;
            end
            S_LOAD: begin
                work_d  = dir_q ? rin : in_q;
                res_d   = '0;
                pend_d  = '0;
                wp_d    = '0;
                cnt_d   = '0;
                mcnt_d  = '0;
                state_d = S_SCAN;
            end
            S_SCAN: begin
                work_d = work_q >> VW;
                cnt_d  = cnt_q + CW'(1);
                if (mrg) begin
                    wr_en  = 1'b1;
                    wr_val = pend_q + VW'(1);
                    pend_d = '0;
                    wp_d   = wp_q + PW'(1);
                    mcnt_d = mcnt_q + MW'(1);
                end else if (tile != '0 && pend_q == '0) begin
                    pend_d = tile;
                end else if (tile != '0) begin
                    wr_en  = 1'b1;
                    wr_val = pend_q;
                    pend_d = tile;
                    wp_d   = wp_q + PW'(1);
                end
                if (cnt_q == CW'(LEN-1)) state_d = S_FLUSH;
            end
            S_FLUSH: begin
                for (int i = 0; i < LEN; i++)
                    if (i >= int'(wp_q)) res_d[i*VW +: VW] = (i == int'(wp_q)) ? pend_q : '0;
                state_d = S_DONE;
            end
            S_DONE: begin
                out_d   = dir_q ? rout : res_q;
                moved_d = (dir_q ? rout : res_q) != in_q;
                mout_d  = mcnt_q;
                done_d  = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
        if (wr_en)
            for (int i = 0; i < LEN; i++)
                if (i == int'(wp_q)) res_d[i*VW +: VW] = wr_val;
    end

    // state and datapath registers; the write pointer must stay inside the line on every write
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            in_q    <= '0;
            dir_q   <= 1'b0;
            work_q  <= '0;
            res_q   <= '0;
            pend_q  <= '0;
            wp_q    <= '0;
            cnt_q   <= '0;
            mcnt_q  <= '0;
            out_q   <= '0;
            moved_q <= 1'b0;
            mout_q  <= '0;
            done_q  <= 1'b0;
        end else begin
            if (wr_en) assert (int'(wp_q) < LEN);
            state_q <= state_d;
            in_q    <= in_d;
            dir_q   <= dir_d;
            work_q  <= work_d;
            res_q   <= res_d;
            pend_q  <= pend_d;
            wp_q    <= wp_d;
            cnt_q   <= cnt_d;
            mcnt_q  <= mcnt_d;
            out_q   <= out_d;
            moved_q <= moved_d;
            mout_q  <= mout_d;
            done_q  <= done_d;
        end
    end

`ifdef LINE_SHIFT_SCORE_EN
    logic [SW-1:0] sacc_q, sacc_d, sout_q, sout_d;

    // score: cleared on load, adds 2**(v+1) per merge, published alongside done
    always_comb begin
        sacc_d = (state_q == S_LOAD) ? '0 :
                 mrg ? sacc_q + (SW'(1) << ({1'b0, pend_q} + (VW+1)'(1))) : sacc_q;
        sout_d = (state_q == S_DONE) ? sacc_q : sout_q;
    end

    // score registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sacc_q <= '0;
            sout_q <= '0;
        end else begin
            sacc_q <= sacc_d;
            sout_q <= sout_d;
        end
    end

    assign score_add = sout_q;
`else
    assign score_add = '0;
`endif

    assign line_out  = out_q;
    assign moved     = moved_q;
    assign merge_cnt = mout_q;
    assign done      = done_q;
    assign busy      = (state_q != S_IDLE) || done_q;
endmodule

// File: tb/tb_line_shift_engine.sv
// tb_line_shift_engine: scoreboard bench for line_shift_engine at LEN=4, VW=4
module tb_line_shift_engine;
    localparam int LEN = 4;
    localparam int VW  = 4;
`ifdef LINE_SHIFT_SCORE_EN
    localparam bit SCORE_ON = 1'b1;
`else
    localparam bit SCORE_ON = 1'b0;
`endif

    typedef struct packed {
        logic [15:0] line;
        logic        moved;
        logic [1:0]  mc;
        logic [16:0] sc;
    } exp_t;

    logic        clk = 1'b0, rst = 1'b1, start = 1'b0, dir = 1'b0;
    logic [15:0] line_in = '0, line_out;
    logic        busy, done, moved;
    logic [1:0]  merge_cnt;
    logic [16:0] score_add;
    int          total = 0, bad = 0;
    exp_t        sb[$];

    always #5 clk = ~clk;

    line_shift_engine #(.LEN(LEN), .VW(VW)) dut (
        .clk(clk), .rst(rst), .start(start), .dir(dir), .line_in(line_in),
        .line_out(line_out), .busy(busy), .done(done), .moved(moved),
        .merge_cnt(merge_cnt), .score_add(score_add)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        total++;
        assert (got === want) else begin
            bad++;
            $error("FAIL %s got=%0h want=%0h", tag, got, want);
        end
    endtask

    function automatic exp_t mk(input logic [15:0] l, input logic mv, input logic [1:0] mc, input int sc);
        exp_t e;
        e.line  = l;
        e.moved = mv;
        e.mc    = mc;
        e.sc    = SCORE_ON ? 17'(sc) : 17'd0;
        return e;
    endfunction

    // reference: gather nonzero tiles in pack order, then merge adjacent equal pairs left to right
    function automatic exp_t model(input logic [15:0] l, input logic d);
        int v[$];
        int o[LEN];
        int k, i, mc, sc;
        logic [15:0] r;
        for (int j = 0; j < LEN; j++) begin
            int t = int'(l[(d ? LEN-1-j : j)*VW +: VW]);
            if (t != 0) v.push_back(t);
            o[j] = 0;
        end
        k = 0; i = 0; mc = 0; sc = 0;
        while (i < v.size()) begin
            if (i + 1 < v.size() && v[i] == v[i+1] && v[i] != 15) begin
                o[k] = v[i] + 1;
                mc++;
                sc += 1 << (v[i] + 1);
                i += 2;
            end else begin
                o[k] = v[i];
                i++;
            end
            k++;
        end
        r = '0;
        for (int j = 0; j < LEN; j++) r[(d ? LEN-1-j : j)*VW +: VW] = 4'(o[j]);
        return mk(r, r != l, 2'(mc), sc);
    endfunction

    // called just before an active edge; ends at the negedge of the cycle after done
    task automatic op(input logic [15:0] l, input logic d, input exp_t e, input bit poke);
        int n;
        exp_t x;
        start = 1'b1; dir = d; line_in = l;
        sb.push_back(e);
        @(posedge clk); #1;
        start = 1'b0;
        chk("busy_on", 32'(busy), 32'd1);
        n = 0;
        while (!done && n < 20) begin
            @(posedge clk); #1;
            n++;
            if (poke && n == 3) begin start = 1'b1; line_in = 16'h1111; dir = ~d; end
            else start = 1'b0;
        end
        chk("latency", 32'(n), 32'd7);
        x = sb.pop_front();
        chk("line_out", 32'(line_out), 32'(x.line));
        chk("moved", 32'(moved), 32'(x.moved));
        chk("merge_cnt", 32'(merge_cnt), 32'(x.mc));
        chk("score_add", 32'(score_add), 32'(x.sc));
        @(posedge clk); #1;
        chk("done_pulse", 32'(done), 32'd0);
        chk("busy_off", 32'(busy), 32'd0);
        @(negedge clk);
    endtask

    initial begin
        int seen;
        exp_t m;
        logic [15:0] l;
        #12;
        chk("rst_line", 32'(line_out), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_moved", 32'(moved), 32'd0);
        chk("rst_mc", 32'(merge_cnt), 32'd0);
        chk("rst_score", 32'(score_add), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        op(16'h1111, 1'b0, mk(16'h0022, 1'b1, 2'd2, 8), 1'b0);
        op(16'h2020, 1'b0, mk(16'h0003, 1'b1, 2'd1, 8), 1'b0);
        op(16'h2011, 1'b1, mk(16'h2200, 1'b1, 2'd1, 4), 1'b0);
        op(16'h4321, 1'b0, mk(16'h4321, 1'b0, 2'd0, 0), 1'b0);
        op(16'h00FF, 1'b0, mk(16'h00FF, 1'b0, 2'd0, 0), 1'b0);
        m = model(16'h0110, 1'b1);
        op(16'h0110, 1'b1, m, 1'b1);
        seen = 0;
        repeat (12) begin @(posedge clk); #1; if (done) seen++; end
        chk("no_extra_done", 32'(seen), 32'd0);
        chk("hold_line", 32'(line_out), 32'(m.line));
        chk("hold_mc", 32'(merge_cnt), 32'(m.mc));
        @(negedge clk);
        start = 1'b1; line_in = 16'h3333; dir = 1'b0;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        chk("abort_line", 32'(line_out), 32'd0);
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_done", 32'(done), 32'd0);
        chk("abort_moved", 32'(moved), 32'd0);
        chk("abort_mc", 32'(merge_cnt), 32'd0);
        chk("abort_score", 32'(score_add), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        seen = 0;
        repeat (12) begin @(posedge clk); #1; if (done) seen++; end
        chk("abort_no_done", 32'(seen), 32'd0);
        @(negedge clk);
        op(16'h3333, 1'b0, mk(16'h0044, 1'b1, 2'd2, 32), 1'b0);
        for (int t = 0; t < 8; t++) begin
            logic d;
            for (int j = 0; j < LEN; j++) l[j*VW +: VW] = 4'($urandom_range(0, 3));
            d = 1'($urandom_range(0, 1));
            op(l, d, model(l, d), 1'b0);
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
